morse_line_scheduler: RTL and testbench

- Sits between `ps2_controller` and `morse_code_encoder`.
- Collects PS/2 make-codes into a line buffer and filters break (F0) and extended (E0) sequences.
- Supports line editing: Backspace deletes the last entry, Esc clears the buffer.
- On Enter, plays the buffered line to the encoder one scancode at a time via a valid/ready handshake, so typing speed never overruns the slow Morse output.

---
 rtl/morse_pkg.sv | 17 +
 rtl/line_fifo.sv | 55 +++++
 rtl/morse_line_scheduler.sv | 128 ++++++++++++
 tb/tb_morse_line_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared scancode constants and scheduler state encoding for the Morse keyboard path.
package morse_pkg;

    localparam logic [7:0] KEY_ENTER    = 8'h5A;
    localparam logic [7:0] KEY_BKSP     = 8'h66;
    localparam logic [7:0] KEY_ESC      = 8'h76;
    localparam logic [7:0] KEY_SPACE    = 8'h29;
    localparam logic [7:0] PREFIX_BREAK = 8'hF0;
    localparam logic [7:0] PREFIX_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        COLLECT      = 2'd0,
        PLAY_PRESENT = 2'd1,
        PLAY_BUBBLE  = 2'd2
    } state_e;

endpackage

// File: rtl/line_fifo.sv
// Line buffer: circular FIFO with an extra "unpush" that retracts the newest entry.
module line_fifo
    import morse_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          unpush_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [7:0]    head_o,
    output logic [CW-1:0] fill_level_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          full, empty;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    // Flush wins; push/unpush/pop are mutually exclusive at the caller but ordered here anyway.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (push_i && !full) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + 1'b1;
            cnt_q       <= cnt_q + 1'b1;
        end else if (unpush_i && !empty) begin
            wr_q  <= wr_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
        end else if (pop_i && !empty) begin
            rd_q  <= rd_q + 1'b1;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign head_o       = mem_q[rd_q];
    assign fill_level_o = cnt_q;

endmodule

// File: rtl/morse_line_scheduler.sv
// Buffers PS/2 make-codes into an editable line and replays it to the Morse encoder on Enter.
module morse_line_scheduler
    import morse_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 ps2_received_data,
    input  logic                       ps2_received_data_strb,
    output logic [7:0]                 char_data,
    output logic                       char_valid,
    input  logic                       char_ready,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       overflow
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e        state_q, state_d;
    logic          brk_q, brk_d, ext_q, ext_d;
    logic          ovf_q, ovf_d;
    logic          make;
    logic          push, unpush, pop, flush;
    logic [7:0]    head;
    logic [CW-1:0] fill;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= COLLECT;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            ovf_q   <= ovf_d;
        end
    end

    // A pending break swallows the next byte whatever it is; an extended prefix swallows the next non-F0.
    always_comb begin
        brk_d = brk_q;
        ext_d = ext_q;
        make  = 1'b0;
        if (ps2_received_data_strb) begin
            if (brk_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (ps2_received_data == PREFIX_BREAK) begin
                brk_d = 1'b1;
            end else if (ext_q) begin
                ext_d = 1'b0;
            end else if (ps2_received_data == PREFIX_EXT) begin
                ext_d = 1'b1;
            end else begin
                make = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unpush  = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        ovf_d   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (make) begin
                    case (ps2_received_data)
                        KEY_ENTER: if (fill != '0) state_d = PLAY_PRESENT;
                        KEY_BKSP:  unpush = (fill != '0);
                        KEY_ESC:   flush = 1'b1;
                        default: begin
                            if (fill == CW'(DEPTH)) ovf_d = 1'b1;
                            else                    push  = 1'b1;
                        end
                    endcase
                end
            end
            PLAY_PRESENT, PLAY_BUBBLE: begin
                // Esc aborts even if a handshake completes in the same cycle.
                if (make && ps2_received_data == KEY_ESC) begin
                    flush   = 1'b1;
                    state_d = COLLECT;
                end else begin
                    if (make && ps2_received_data != KEY_ENTER && ps2_received_data != KEY_BKSP)
                        ovf_d = 1'b1;
                    if (state_q == PLAY_BUBBLE) begin
                        state_d = PLAY_PRESENT;
                    end else if (char_ready) begin
                        if (fill == CW'(1)) begin
                            flush   = 1'b1;
                            state_d = COLLECT;
                        end else begin
                            pop     = 1'b1;
                            state_d = PLAY_BUBBLE;
                        end
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    line_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .data_i       (ps2_received_data),
        .unpush_i     (unpush),
        .pop_i        (pop),
        .flush_i      (flush),
        .head_o       (head),
        .fill_level_o (fill)
    );

    assign char_valid = (state_q == PLAY_PRESENT);
    assign char_data  = char_valid ? head : 8'h00;
    assign busy       = (state_q != COLLECT);
    assign fill_level = fill;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_morse_line_scheduler.sv
// Self-checking bench: table vectors, hand-written corner sequences, and randomized lines vs a queue model.
module tb_morse_line_scheduler;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       strb = 1'b0;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready = 1'b0;
    logic       busy;
    logic [4:0] fill_level;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_line[$];
    bit         m_brk = 0, m_ext = 0;

    always #10 clk = ~clk;

    morse_line_scheduler #(.DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ps2_received_data      (din),
        .ps2_received_data_strb (strb),
        .char_data              (char_data),
        .char_valid             (char_valid),
        .char_ready             (char_ready),
        .busy                   (busy),
        .fill_level             (fill_level),
        .overflow               (overflow)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic send(input logic [7:0] b);
        din  = b;
        strb = 1'b1;
        @(negedge clk);
        strb = 1'b0;
        din  = 8'h00;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        strb       = 1'b0;
        char_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_line.delete();
        m_brk = 0;
        m_ext = 0;
    endtask

    // Reference: keyboard rules applied to a plain queue holding the line.
    task automatic model_key(input logic [7:0] b, output bit drop, output bit play);
        drop = 0;
        play = 0;
        if (m_brk) begin
            m_brk = 0;
            m_ext = 0;
        end else if (b == 8'hF0) m_brk = 1;
        else if (m_ext) m_ext = 0;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'h5A) play = (m_line.size() > 0);
        else if (b == 8'h66) begin
            if (m_line.size() > 0) void'(m_line.pop_back());
        end else if (b == 8'h76) m_line.delete();
        else if (m_line.size() == DEPTH) drop = 1;
        else m_line.push_back(b);
    endtask

    // Drains a line: records every handshake and checks char_data holds while stalled.
    task automatic play_capture(input bit rnd);
        int         cyc = 0;
        int         stab_err = 0;
        bit         hold = 0;
        logic [7:0] held = 8'h00;
        got_q.delete();
        while (busy && cyc < 2000) begin
            if (hold && (!char_valid || char_data != held)) stab_err++;
            char_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (char_valid && char_ready) got_q.push_back(char_data);
            hold = char_valid && !char_ready;
            held = char_data;
            @(negedge clk);
            cyc++;
        end
        char_ready = 1'b0;
        chk("play_terminates", int'(busy), 0);
        chk("play_data_stable", stab_err, 0);
    endtask

    typedef struct {
        string       name;
        logic [63:0] keys;
        int          nk;
        logic [31:0] exp;
        int          ne;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0] b;
        logic [7:0] pool[9];
        bit         drop, play;
        int         stable;

        vecs[0] = '{"basic",    64'h1C29_325A_0000_0000, 4, 32'h1C29_3200, 3};
        vecs[1] = '{"prefix",   64'h1CF0_1CE0_F021_325A, 8, 32'h1C32_0000, 2};
        vecs[2] = '{"bksp",     64'h1C32_6621_5A00_0000, 5, 32'h1C21_0000, 2};
        vecs[3] = '{"esc_ext",  64'h290C_7621_E075_295A, 8, 32'h2129_0000, 2};
        pool    = '{8'h1C, 8'h29, 8'h32, 8'h21, 8'h0C, 8'h66, 8'h76, 8'hF0, 8'hE0};

        // Reset state
        do_reset();
        chk("rst_valid", int'(char_valid), 0);
        chk("rst_data", int'(char_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fill", int'(fill_level), 0);
        chk("rst_ovf", int'(overflow), 0);

        // Table vectors
        foreach (vecs[v]) begin
            do_reset();
            for (int i = 0; i < vecs[v].nk; i++) begin
                b = vecs[v].keys[63 - 8*i -: 8];
                if (i == vecs[v].nk - 1) chk({vecs[v].name, "_fill"}, int'(fill_level), vecs[v].ne);
                send(b);
            end
            play_capture(0);
            chk({vecs[v].name, "_len"}, got_q.size(), vecs[v].ne);
            for (int i = 0; i < vecs[v].ne && i < got_q.size(); i++)
                chk({vecs[v].name, "_byte"}, int'(got_q[i]), int'(vecs[v].exp[31 - 8*i -: 8]));
        end

        // Backspace / Enter on an empty buffer do nothing
        send(8'h66);
        send(8'h5A);
        chk("empty_enter_busy", int'(busy), 0);
        @(negedge clk);
        chk("empty_enter_valid", int'(char_valid), 0);
        chk("empty_enter_fill", int'(fill_level), 0);

        // Cycle-accurate playback with a bubble between characters
        do_reset();
        char_ready = 1'b1;
        send(8'h1C); send(8'h29); send(8'h32); send(8'h5A);
        chk("cyc_v0", int'(char_valid), 1); chk("cyc_d0", int'(char_data), 8'h1C);
        chk("cyc_f0", int'(fill_level), 3);
        @(negedge clk);
        chk("cyc_b0", int'(char_valid), 0); chk("cyc_f1", int'(fill_level), 2);
        @(negedge clk);
        chk("cyc_v1", int'(char_valid), 1); chk("cyc_d1", int'(char_data), 8'h29);
        @(negedge clk);
        chk("cyc_b1", int'(char_valid), 0);
        @(negedge clk);
        chk("cyc_v2", int'(char_valid), 1); chk("cyc_d2", int'(char_data), 8'h32);
        chk("cyc_busy2", int'(busy), 1);
        @(negedge clk);
        chk("cyc_end_valid", int'(char_valid), 0);
        chk("cyc_end_busy", int'(busy), 0);
        chk("cyc_end_fill", int'(fill_level), 0);
        char_ready = 1'b0;

        // Overflow at DEPTH+1
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            send(8'h1C);
            chk("full_ovf", int'(overflow), (i == DEPTH) ? 1 : 0);
        end
        chk("full_fill", int'(fill_level), DEPTH);
        @(negedge clk);
        chk("full_ovf_pulse", int'(overflow), 0);
        send(8'h5A);
        play_capture(0);
        chk("full_xfers", got_q.size(), DEPTH);

        // Stall, drop during play, then Esc abort
        do_reset();
        send(8'h1C); send(8'h32); send(8'h21); send(8'h5A);
        stable = 0;
        for (int c = 0; c < 100; c++) begin
            if (char_valid && char_data == 8'h1C) stable++;
            if (c == 50) begin
                send(8'h0C);
                chk("stall_ovf", int'(overflow), 1);
            end else begin
                @(negedge clk);
            end
        end
        chk("stall_stable", stable, 100);
        chk("stall_fill", int'(fill_level), 3);
        send(8'h76);
        chk("esc_valid", int'(char_valid), 0);
        chk("esc_fill", int'(fill_level), 0);
        chk("esc_busy", int'(busy), 0);

        // Reset mid-play
        do_reset();
        send(8'h1C); send(8'h32); send(8'h5A);
        char_ready = 1'b1;
        chk("midrst_v", int'(char_valid), 1);
        @(negedge clk);
        chk("midrst_fill", int'(fill_level), 1);
        rst = 1'b0;
        char_ready = 1'b0;
        @(negedge clk);
        chk("midrst_valid", int'(char_valid), 0);
        chk("midrst_data", int'(char_data), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_fill0", int'(fill_level), 0);
        chk("midrst_ovf", int'(overflow), 0);
        rst = 1'b1;
        send(8'h21); send(8'h5A);
        play_capture(0);
        chk("midrst_len", got_q.size(), 1);
        if (got_q.size() > 0) chk("midrst_byte", int'(got_q[0]), 8'h21);

        // Randomized lines against the queue model
        do_reset();
        for (int it = 0; it < 20; it++) begin
            int n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                b = pool[$urandom_range(0, 8)];
                model_key(b, drop, play);
                send(b);
                chk("rand_ovf", int'(overflow), int'(drop));
                chk("rand_fill", int'(fill_level), m_line.size());
            end
            model_key(8'h5A, drop, play);
            send(8'h5A);
            if (!play && m_line.size() > 0) begin
                model_key(8'h5A, drop, play);
                send(8'h5A);
            end
            if (play) begin
                exp_q = m_line;
                play_capture(1);
                chk("rand_len", got_q.size(), exp_q.size());
                for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                    chk("rand_byte", int'(got_q[i]), int'(exp_q[i]));
                m_line.delete();
            end else begin
                chk("rand_idle_busy", int'(busy), 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
